fifo_sp_rd_ctrl: RTL and testbench

Read-side controller for the single-port-RAM FIFO (`fifo_sp_ram`). It owns the FIFO's read strobe and the write/read port-select, pops words whenever the FIFO is non-empty and the upstream writer is not requesting the port, and presents them on a valid/ready stream with a 2-entry skid buffer. It sits between the FIFO and any streaming consumer (UART/SPI transmitters) and sustains one word per cycle when neither side stalls.

---
 rtl/fifo_sp_rd_ctrl.sv | 145 ++++++++++++++
 tb/tb_fifo_sp_rd_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sp_rd_ctrl.sv
// Read-side controller for the single-port-RAM FIFO: pops words when the writer
// leaves the port free and streams them out through a 2-entry skid buffer.
module fifo_sp_rd_ctrl #(
  parameter int BIT_D = 32,
  parameter int CNT_W = 3
) (
  input  logic             clk_i,
  input  logic             arstn_i,
  input  logic             en_i,
  input  logic             wr_req_i,
  output logic             fifo_rd_o,
  output logic             fifo_sel_wr_rd_o,
  input  logic [BIT_D-1:0] fifo_data_i,
  input  logic             fifo_empty_i,
  input  logic [CNT_W-1:0] fifo_cnt_i,
  output logic [BIT_D-1:0] m_data_o,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [15:0]      rd_words_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             inflight_q, inflight_d;
  logic [1:0]       buf_cnt_q, buf_cnt_d;
  logic [BIT_D-1:0] buf0_q, buf0_d;
  logic [BIT_D-1:0] buf1_q, buf1_d;
  logic [15:0]      words_q, words_d;
  logic             pop;
  logic             take;
  logic             busy;
  logic [2:0]       occ;
  logic             unused_cnt;

  // The fill count is informational; flow control uses the empty flag only.
  assign unused_cnt = ^fifo_cnt_i;

  assign take = (buf_cnt_q != 2'd0) && m_ready_i;
  assign occ  = {1'b0, buf_cnt_q} + {2'b00, inflight_q};

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (en_i) state_d = RUN;
        else      state_d = IDLE;
      end
      RUN: begin
        if (!en_i) state_d = FLUSH;
        else       state_d = RUN;
      end
      FLUSH: begin
        if (en_i)                                      state_d = RUN;
        else if (!inflight_q && (buf_cnt_q == 2'd0))   state_d = IDLE;
        else                                           state_d = FLUSH;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pop is combinational so a writer request blocks it in the same cycle.
  always_comb begin
    pop  = 1'b0;
    busy = (state_q != IDLE);
    case (state_q)
      RUN: begin
        if (en_i && !fifo_empty_i && !wr_req_i && (occ < (3'd2 + {2'b00, take})))
          pop = 1'b1;
        else
          pop = 1'b0;
      end
      default: pop = 1'b0;
    endcase
  end

  always_comb begin
    buf0_d     = buf0_q;
    buf1_d     = buf1_q;
    buf_cnt_d  = buf_cnt_q;
    inflight_d = pop;
    if (take) words_d = words_q + 16'd1;
    else      words_d = words_q;
    // Head is always buf0; a take shifts buf1 forward, a capture fills the next free slot.
    case ({inflight_q, take})
      2'b10: begin
        if (buf_cnt_q == 2'd0) buf0_d = fifo_data_i;
        else                   buf1_d = fifo_data_i;
        buf_cnt_d = buf_cnt_q + 2'd1;
      end
      2'b01: begin
        buf0_d    = buf1_q;
        buf_cnt_d = buf_cnt_q - 2'd1;
      end
      2'b11: begin
        if (buf_cnt_q == 2'd1) begin
          buf0_d = fifo_data_i;
        end else begin
          buf0_d = buf1_q;
          buf1_d = fifo_data_i;
        end
      end
      default: begin
        buf_cnt_d = buf_cnt_q;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      inflight_q <= 1'b0;
      buf_cnt_q  <= 2'd0;
      buf0_q     <= '0;
      buf1_q     <= '0;
      words_q    <= 16'd0;
    end else begin
      inflight_q <= inflight_d;
      buf_cnt_q  <= buf_cnt_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      words_q    <= words_d;
    end
  end

  assign fifo_rd_o        = pop;
  assign fifo_sel_wr_rd_o = pop;
  assign m_data_o         = buf0_q;
  assign m_valid_o        = (buf_cnt_q != 2'd0);
  assign rd_words_o       = words_q;
  assign busy_o           = busy;

endmodule

// File: tb/tb_fifo_sp_rd_ctrl.sv
// Bench for fifo_sp_rd_ctrl: behavioural FIFO model, per-cycle vector table and
// directed sequences for stall, enable drop, reset and counter wrap.
module tb_fifo_sp_rd_ctrl;
  localparam int BIT_D = 32;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             arstn_i, en_i, wr_req_i, m_ready_i;
  logic             fifo_rd_o, fifo_sel_wr_rd_o, m_valid_o, busy_o;
  logic [BIT_D-1:0] m_data_o;
  logic [15:0]      rd_words_o;
  logic [BIT_D-1:0] fifo_data_q  = '0;
  logic             fifo_empty_q = 1'b1;
  logic [CNT_W-1:0] fifo_cnt_q   = '0;

  fifo_sp_rd_ctrl #(.BIT_D(BIT_D), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .arstn_i(arstn_i), .en_i(en_i), .wr_req_i(wr_req_i),
    .fifo_rd_o(fifo_rd_o), .fifo_sel_wr_rd_o(fifo_sel_wr_rd_o),
    .fifo_data_i(fifo_data_q), .fifo_empty_i(fifo_empty_q), .fifo_cnt_i(fifo_cnt_q),
    .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
    .rd_words_o(rd_words_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  logic [BIT_D-1:0] mem[$];
  logic [BIT_D-1:0] sb[$];
  int tests = 0, fails = 0;
  int hs_total = 0, pop_total = 0, sb_err = 0, cyc = 0;
  logic [BIT_D-1:0] last_hs = '0;

  // FIFO model: data one cycle after a pop, empty/count registered on the pop edge
  always @(posedge clk) begin
    cyc++;
    if (fifo_rd_o && fifo_sel_wr_rd_o && mem.size() > 0) fifo_data_q <= mem.pop_front();
    fifo_empty_q <= (mem.size() == 0);
    fifo_cnt_q   <= CNT_W'(mem.size());
  end

  // Stream monitor: a valid&ready seen here completes on the next rising edge
  always @(negedge clk) begin
    if (arstn_i && fifo_rd_o) pop_total++;
    if (arstn_i && m_valid_o && m_ready_i) begin
      hs_total++;
      last_hs = m_data_o;
      if (sb.size() == 0) sb_err++;
      else begin
        if (sb[0] != m_data_o) sb_err++;
        sb.delete(0);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk); #1;
  endtask

  task automatic push_word(input logic [BIT_D-1:0] d);
    mem.push_back(d);
    sb.push_back(d);
  endtask

  task automatic wait_hs(input int target, input int bound, input string name);
    int n = 0;
    while (hs_total < target && n < bound) begin
      sample();
      n++;
    end
    check({name, "_timeout"}, 32'(hs_total >= target), 32'd1);
    step();
  endtask

  task automatic wait_idle(input int bound, input string name);
    int n = 0;
    sample();
    while (busy_o && n < bound) begin
      sample();
      n++;
    end
    check(name, 32'(busy_o), 32'd0);
  endtask

  typedef struct {
    logic        push;
    logic [31:0] push_d;
    logic        en;
    logic        wr;
    logic        rdy;
    logic        exp_rd;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic [15:0] exp_words;
  } vec_t;

  vec_t vecs[17];

  initial begin
    int h0, p0, c0, c1, stable_err;
    // streaming 7,8,6 then writer priority on word 10
    vecs[0]  = '{1'b1, 32'd7,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0,  16'd0};
    vecs[1]  = '{1'b1, 32'd8,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0,  16'd0};
    vecs[2]  = '{1'b1, 32'd6,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0,  16'd0};
    vecs[3]  = '{1'b0, 32'd0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0,  16'd0};
    vecs[4]  = '{1'b0, 32'd0,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0,  16'd0};
    vecs[5]  = '{1'b0, 32'd0,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0,  16'd0};
    vecs[6]  = '{1'b0, 32'd0,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'd7,  16'd0};
    vecs[7]  = '{1'b0, 32'd0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'd8,  16'd1};
    vecs[8]  = '{1'b0, 32'd0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'd6,  16'd2};
    vecs[9]  = '{1'b0, 32'd0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0,  16'd3};
    vecs[10] = '{1'b1, 32'd10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0,  16'd3};
    vecs[11] = '{1'b0, 32'd0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0,  16'd3};
    vecs[12] = '{1'b0, 32'd0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0,  16'd3};
    vecs[13] = '{1'b0, 32'd0,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0,  16'd3};
    vecs[14] = '{1'b0, 32'd0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0,  16'd3};
    vecs[15] = '{1'b0, 32'd0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'd10, 16'd3};
    vecs[16] = '{1'b0, 32'd0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0,  16'd4};

    arstn_i = 1'b0; en_i = 1'b0; wr_req_i = 1'b0; m_ready_i = 1'b1;
    #2;
    check("rst_rd",    32'(fifo_rd_o), 32'd0);
    check("rst_sel",   32'(fifo_sel_wr_rd_o), 32'd0);
    check("rst_valid", 32'(m_valid_o), 32'd0);
    check("rst_busy",  32'(busy_o), 32'd0);
    check("rst_data",  m_data_o, 32'd0);
    check("rst_words", 32'(rd_words_o), 32'd0);
    step();
    arstn_i = 1'b1;

    for (int i = 0; i < 17; i++) begin
      step();
      en_i = vecs[i].en; wr_req_i = vecs[i].wr; m_ready_i = vecs[i].rdy;
      if (vecs[i].push) push_word(vecs[i].push_d);
      sample();
      check($sformatf("v%0d_rd", i),    32'(fifo_rd_o), 32'(vecs[i].exp_rd));
      check($sformatf("v%0d_sel", i),   32'(fifo_sel_wr_rd_o), 32'(vecs[i].exp_rd));
      check($sformatf("v%0d_valid", i), 32'(m_valid_o), 32'(vecs[i].exp_valid));
      check($sformatf("v%0d_words", i), 32'(rd_words_o), 32'(vecs[i].exp_words));
      if (vecs[i].exp_valid) check($sformatf("v%0d_data", i), m_data_o, vecs[i].exp_data);
    end

    // consumer stall
    step();
    m_ready_i = 1'b0;
    push_word(32'd12); push_word(32'd4); push_word(32'd9); push_word(32'd1);
    p0 = pop_total;
    repeat (6) step();
    sample();
    check("stall_pops",  32'(pop_total - p0), 32'd2);
    check("stall_valid", 32'(m_valid_o), 32'd1);
    check("stall_data",  m_data_o, 32'd12);
    check("stall_cnt",   32'(fifo_cnt_q), 32'd2);
    stable_err = 0;
    repeat (3) begin
      step(); sample();
      if (!m_valid_o || m_data_o != 32'd12) stable_err++;
    end
    check("stall_stable", 32'(stable_err), 32'd0);
    step();
    m_ready_i = 1'b1;
    h0 = hs_total;
    wait_hs(h0 + 4, 20, "stall_drain");
    check("stall_last",  last_hs, 32'd1);
    check("stall_words", 32'(rd_words_o), 32'd8);

    // enable drop: two pops then en_i low, three words stay in the FIFO
    en_i = 1'b0;
    wait_idle(20, "pre_drop_idle");
    step();
    for (int i = 21; i <= 25; i++) push_word(32'(i));
    step(); step();
    p0 = pop_total; h0 = hs_total;
    en_i = 1'b1;
    step();
    sample();
    check("drop_first_pop", 32'(fifo_rd_o), 32'd1);
    step(); step();
    en_i = 1'b0;
    wait_idle(30, "drop_idle");
    check("drop_pops",   32'(pop_total - p0), 32'd2);
    check("drop_hs",     32'(hs_total - h0), 32'd2);
    check("drop_remain", 32'(mem.size()), 32'd3);
    check("drop_last",   last_hs, 32'd22);
    check("drop_words",  32'(rd_words_o), 32'd10);

    // reset with two words buffered
    step();
    m_ready_i = 1'b0; en_i = 1'b1;
    repeat (6) step();
    sample();
    check("pre_rst_valid", 32'(m_valid_o), 32'd1);
    check("pre_rst_data",  m_data_o, 32'd23);
    arstn_i = 1'b0;
    #1;
    check("arst_valid", 32'(m_valid_o), 32'd0);
    check("arst_rd",    32'(fifo_rd_o), 32'd0);
    check("arst_sel",   32'(fifo_sel_wr_rd_o), 32'd0);
    check("arst_words", 32'(rd_words_o), 32'd0);
    check("arst_busy",  32'(busy_o), 32'd0);
    sb.delete(0); sb.delete(0);
    m_ready_i = 1'b1;
    step();
    arstn_i = 1'b1;
    h0 = hs_total;
    wait_hs(h0 + 1, 10, "post_rst");
    check("post_rst_data",  last_hs, 32'd25);
    check("post_rst_words", 32'(rd_words_o), 32'd1);

    // counter wrap
    step();
    arstn_i = 1'b0;
    step();
    arstn_i = 1'b1;
    h0 = hs_total; c0 = cyc;
    push_word(32'h8000_0000); push_word(32'h8000_0001); push_word(32'h8000_0002);
    for (int i = 3; i < 65535; i++) begin
      step();
      push_word(32'h8000_0000 + 32'(i));
    end
    wait_hs(h0 + 65535, 50, "wrap_ffff");
    c1 = cyc;
    check("wrap_ffff_words", 32'(rd_words_o), 32'h0000_FFFF);
    check("throughput", 32'((c1 - c0) < 65535 + 20), 32'd1);
    push_word(32'h8000_FFFF);
    wait_hs(h0 + 65536, 20, "wrap_zero");
    check("wrap_zero_words", 32'(rd_words_o), 32'd0);

    check("sb_order", 32'(sb_err), 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
